idex_skid_stage: RTL and testbench

- Parametrised successor to the fixed-width ID/EX pipeline register.
- Decode-to-execute stage register with a valid/ready handshake on both sides and a one-entry skid buffer, so `in_ready` is driven from a flop.
- Keeps the existing flush-to-NOP and replay (stall re-issue) behaviour.
- Sits between the decode/register-file read stage and the ALU/execute stage.

---
 rtl/idex_skid_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_idex_skid_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/idex_skid_stage.sv
// -----------------------------------------------------------------------------
// idex_skid_stage
//
// Decode-to-execute pipeline stage register with valid/ready handshaking on
// both sides and a one-entry skid buffer. Because of the skid buffer,
// in_ready is driven straight from a flop and never combinationally from
// out_ready.
//
// Supported operations:
//   - Flush: drops every held beat and the beat presented in the same cycle.
//     The output becomes a NOP bubble.
//   - Replay: rewrites the control fields (opcode and addresses) of the beat
//     currently held in the output register. The data fields are kept.
//
// Cycle priority: flush > replay > normal handshake.
//
// Optional build feature IDEX_SKID_STATS_EN (`define to enable):
//   Adds the saturating 16-bit counters bubble_cnt and replay_cnt.
//
// Parameters:
//   OPW        opcode width
//   RDAW       destination register address width
//   RSAW       source register address width
//   DW         data width
//   NOP_OPCODE opcode loaded on reset, on flush and for a bubble
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   in_valid / in_ready        decode-side handshake (in_ready is registered)
//   in_*                       decoded beat fields
//   out_valid / out_ready      execute-side handshake
//   out_*                      registered stage contents
//   flush                      discard held and incoming beats
//   replay, replay_*           in-place rewrite of the output control fields
//   bubble_cnt, replay_cnt     statistics (only with IDEX_SKID_STATS_EN)
// -----------------------------------------------------------------------------
module idex_skid_stage #(
    parameter int              OPW        = 5,
    parameter int              RDAW       = 3,
    parameter int              RSAW       = 4,
    parameter int              DW         = 8,
    parameter logic [OPW-1:0]  NOP_OPCODE = 5'h1f
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [RDAW-1:0]  in_rd_addr,
    input  logic [RSAW-1:0]  in_r1_addr,
    input  logic [RSAW-1:0]  in_r2_addr,
    input  logic [DW-1:0]    in_rd_data,
    input  logic [DW-1:0]    in_r1_data,
    input  logic [DW-1:0]    in_r2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_opcode,
    output logic [RDAW-1:0]  out_rd_addr,
    output logic [RSAW-1:0]  out_r1_addr,
    output logic [RSAW-1:0]  out_r2_addr,
    output logic [DW-1:0]    out_rd_data,
    output logic [DW-1:0]    out_r1_data,
    output logic [DW-1:0]    out_r2_data,
    input  logic             flush,
    input  logic             replay,
    input  logic [OPW-1:0]   replay_opcode,
    input  logic [RDAW-1:0]  replay_rd_addr,
    input  logic [RSAW-1:0]  replay_r1_addr,
    input  logic [RSAW-1:0]  replay_r2_addr
`ifdef IDEX_SKID_STATS_EN
    ,
    output logic [15:0]      bubble_cnt,
    output logic [15:0]      replay_cnt
`endif
);

    typedef struct packed {
        logic [OPW-1:0]  opcode;
        logic [RDAW-1:0] rd_addr;
        logic [RSAW-1:0] r1_addr;
        logic [RSAW-1:0] r2_addr;
        logic [DW-1:0]   rd_data;
        logic [DW-1:0]   r1_data;
        logic [DW-1:0]   r2_data;
    } beat_t;

    // The NOP beat used for reset, flush and bubbles.
    function automatic beat_t nop_beat();
        beat_t b;
        b        = '0;
        b.opcode = NOP_OPCODE;
        return b;
    endfunction

    beat_t o_q, o_d;      // output register
    beat_t s_q, s_d;      // skid register
    logic  ov_q, ov_d;
    logic  sv_q, sv_d;
    logic  in_ready_q, in_ready_d;

    logic  in_fire_s;
    logic  out_fire_s;
    logic  replay_acc_s;
    beat_t in_beat_s;

    // Firing conditions and packing of the incoming beat.
    always_comb begin
        in_fire_s    = in_valid & in_ready_q & ~flush;
        out_fire_s   = ov_q & out_ready & ~replay & ~flush;
        replay_acc_s = replay & ov_q & ~flush;
        in_beat_s.opcode  = in_opcode;
        in_beat_s.rd_addr = in_rd_addr;
        in_beat_s.r1_addr = in_r1_addr;
        in_beat_s.r2_addr = in_r2_addr;
        in_beat_s.rd_data = in_rd_data;
        in_beat_s.r1_data = in_r1_data;
        in_beat_s.r2_data = in_r2_data;
    end

    // Next-state logic for the output and skid registers.
    always_comb begin
        o_d  = o_q;
        s_d  = s_q;
        ov_d = ov_q;
        sv_d = sv_q;
        if (flush) begin
            o_d  = nop_beat();
            s_d  = nop_beat();
            ov_d = 1'b0;
            sv_d = 1'b0;
        end else if (replay_acc_s) begin
            // Control fields are rewritten in place. The data fields stay and
            // nothing is transferred out. A new beat can still park in S.
            o_d.opcode  = replay_opcode;
            o_d.rd_addr = replay_rd_addr;
            o_d.r1_addr = replay_r1_addr;
            o_d.r2_addr = replay_r2_addr;
            ov_d        = 1'b1;
            if (in_fire_s) begin
                s_d  = in_beat_s;
                sv_d = 1'b1;
            end else begin
                sv_d = sv_q;
            end
        end else if (!ov_q || out_fire_s) begin
            // O is free this cycle. The skid entry is older, so it goes first.
            if (sv_q) begin
                o_d  = s_q;
                ov_d = 1'b1;
                if (in_fire_s) begin
                    s_d  = in_beat_s;
                    sv_d = 1'b1;
                end else begin
                    sv_d = 1'b0;
                end
            end else if (in_fire_s) begin
                o_d  = in_beat_s;
                ov_d = 1'b1;
            end else begin
                o_d  = nop_beat();
                ov_d = 1'b0;
            end
        end else begin
            // O is stalled. A new beat parks in the skid register.
            if (in_fire_s) begin
                s_d  = in_beat_s;
                sv_d = 1'b1;
            end else begin
                sv_d = sv_q;
            end
        end
        in_ready_d = ~sv_d;
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_q        <= nop_beat();
            s_q        <= nop_beat();
            ov_q       <= 1'b0;
            sv_q       <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            o_q        <= o_d;
            s_q        <= s_d;
            ov_q       <= ov_d;
            sv_q       <= sv_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = ov_q;
    assign out_opcode  = o_q.opcode;
    assign out_rd_addr = o_q.rd_addr;
    assign out_r1_addr = o_q.r1_addr;
    assign out_r2_addr = o_q.r2_addr;
    assign out_rd_data = o_q.rd_data;
    assign out_r1_data = o_q.r1_data;
    assign out_r2_data = o_q.r2_data;

`ifdef IDEX_SKID_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : (v + 16'd1);
    endfunction

    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] replay_cnt_q, replay_cnt_d;

    // Saturating statistics counters. Flush does not clear them.
    always_comb begin
        if (!ov_q) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
        if (replay_acc_s) begin
            replay_cnt_d = sat_inc(replay_cnt_q);
        end else begin
            replay_cnt_d = replay_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= 16'd0;
            replay_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            replay_cnt_q <= replay_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign replay_cnt = replay_cnt_q;
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
module tb_idex_skid_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_opcode;
    logic [2:0] in_rd_addr;
    logic [3:0] in_r1_addr;
    logic [3:0] in_r2_addr;
    logic [7:0] in_rd_data;
    logic [7:0] in_r1_data;
    logic [7:0] in_r2_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_opcode;
    logic [2:0] out_rd_addr;
    logic [3:0] out_r1_addr;
    logic [3:0] out_r2_addr;
    logic [7:0] out_rd_data;
    logic [7:0] out_r1_data;
    logic [7:0] out_r2_data;
    logic       flush;
    logic       replay;
    logic [4:0] replay_opcode;
    logic [2:0] replay_rd_addr;
    logic [3:0] replay_r1_addr;
    logic [3:0] replay_r2_addr;
`ifdef IDEX_SKID_STATS_EN
    logic [15:0] bubble_cnt;
    logic [15:0] replay_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    idex_skid_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_rd_addr     (in_rd_addr),
        .in_r1_addr     (in_r1_addr),
        .in_r2_addr     (in_r2_addr),
        .in_rd_data     (in_rd_data),
        .in_r1_data     (in_r1_data),
        .in_r2_data     (in_r2_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_rd_addr    (out_rd_addr),
        .out_r1_addr    (out_r1_addr),
        .out_r2_addr    (out_r2_addr),
        .out_rd_data    (out_rd_data),
        .out_r1_data    (out_r1_data),
        .out_r2_data    (out_r2_data),
        .flush          (flush),
        .replay         (replay),
        .replay_opcode  (replay_opcode),
        .replay_rd_addr (replay_rd_addr),
        .replay_r1_addr (replay_r1_addr),
        .replay_r2_addr (replay_r2_addr)
`ifdef IDEX_SKID_STATS_EN
        ,
        .bubble_cnt     (bubble_cnt),
        .replay_cnt     (replay_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input beats always carry rd_addr=6, r2_addr=9, r2_data=5c.
    // Replays always use rd_addr=2, r2_addr=1.
    typedef struct {
        logic       iv;
        logic [4:0] op;
        logic [3:0] r1a;
        logic [7:0] r1d;
        logic [7:0] rdd;
        logic       ordy;
        logic       fl;
        logic       rp;
        logic [4:0] rpop;
        logic [3:0] rpr1;
        logic       eov;
        logic [4:0] eop;
        logic [2:0] erda;
        logic [3:0] er1a;
        logic [3:0] er2a;
        logic [7:0] er1d;
        logic [7:0] erdd;
        logic       erdy;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [4:0] op, input logic [3:0] r1a,
                       input logic [7:0] r1d, input logic [7:0] rdd, input logic ordy,
                       input logic fl, input logic rp, input logic [4:0] rpop,
                       input logic [3:0] rpr1, input logic eov, input logic [4:0] eop,
                       input logic [2:0] erda, input logic [3:0] er1a, input logic [3:0] er2a,
                       input logic [7:0] er1d, input logic [7:0] erdd, input logic erdy,
                       input string name);
        vec_t v;
        v.iv = iv; v.op = op; v.r1a = r1a; v.r1d = r1d; v.rdd = rdd; v.ordy = ordy;
        v.fl = fl; v.rp = rp; v.rpop = rpop; v.rpr1 = rpr1;
        v.eov = eov; v.eop = eop; v.erda = erda; v.er1a = er1a; v.er2a = er2a;
        v.er1d = er1d; v.erdd = erdd; v.erdy = erdy; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_opcode = 5'h00; in_rd_addr = 3'h6; in_r1_addr = 4'h0;
        in_r2_addr = 4'h9; in_rd_data = 8'h00; in_r1_data = 8'h00; in_r2_data = 8'h5c;
        out_ready = 1'b0; flush = 1'b0; replay = 1'b0; replay_opcode = 5'h00;
        replay_rd_addr = 3'h2; replay_r1_addr = 4'h0; replay_r2_addr = 4'h1;
    endtask

    task automatic check_outputs(input string tag, input logic eov, input logic [4:0] eop,
                                 input logic [2:0] erda, input logic [3:0] er1a,
                                 input logic [3:0] er2a, input logic [7:0] er1d,
                                 input logic [7:0] erdd, input logic erdy);
        check({tag, ".out_valid"},   {31'd0, out_valid},   {31'd0, eov});
        check({tag, ".out_opcode"},  {27'd0, out_opcode},  {27'd0, eop});
        check({tag, ".out_rd_addr"}, {29'd0, out_rd_addr}, {29'd0, erda});
        check({tag, ".out_r1_addr"}, {28'd0, out_r1_addr}, {28'd0, er1a});
        check({tag, ".out_r2_addr"}, {28'd0, out_r2_addr}, {28'd0, er2a});
        check({tag, ".out_r1_data"}, {24'd0, out_r1_data}, {24'd0, er1d});
        check({tag, ".out_rd_data"}, {24'd0, out_rd_data}, {24'd0, erdd});
        check({tag, ".out_r2_data"}, {24'd0, out_r2_data}, eov ? 32'h5c : 32'h0);
        check({tag, ".in_ready"},    {31'd0, in_ready},    {31'd0, erdy});
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;

        // Columns: iv op r1a r1d rdd ordy fl rp rpop rpr1 | eov eop erda er1a er2a er1d erdd erdy
        // Streaming at full throughput
        add(1, 5'h01, 4'h1, 8'h11, 8'h01, 1, 0, 0, 5'h00, 4'h0, 1, 5'h01, 3'h6, 4'h1, 4'h9, 8'h11, 8'h01, 1, "stream1");
        add(1, 5'h02, 4'h2, 8'h22, 8'h02, 1, 0, 0, 5'h00, 4'h0, 1, 5'h02, 3'h6, 4'h2, 4'h9, 8'h22, 8'h02, 1, "stream2");
        add(1, 5'h03, 4'h3, 8'h33, 8'h03, 1, 0, 0, 5'h00, 4'h0, 1, 5'h03, 3'h6, 4'h3, 4'h9, 8'h33, 8'h03, 1, "stream3");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "bubble1");
        // Backpressure into the skid register
        add(1, 5'h04, 4'h4, 8'h44, 8'h04, 0, 0, 0, 5'h00, 4'h0, 1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 1, "bp_o4");
        add(1, 5'h05, 4'h5, 8'h55, 8'h05, 0, 0, 0, 5'h00, 4'h0, 1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 0, "bp_s5");
        add(1, 5'h06, 4'h6, 8'h66, 8'h06, 0, 0, 0, 5'h00, 4'h0, 1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 0, "bp_hold6");
        add(1, 5'h06, 4'h6, 8'h66, 8'h06, 1, 0, 0, 5'h00, 4'h0, 1, 5'h05, 3'h6, 4'h5, 4'h9, 8'h55, 8'h05, 1, "drain5");
        add(1, 5'h06, 4'h6, 8'h66, 8'h06, 1, 0, 0, 5'h00, 4'h0, 1, 5'h06, 3'h6, 4'h6, 4'h9, 8'h66, 8'h06, 1, "drain6");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "bubble2");
        // Flush with the skid register full
        add(1, 5'h04, 4'h4, 8'h44, 8'h04, 0, 0, 0, 5'h00, 4'h0, 1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 1, "fl_o4");
        add(1, 5'h05, 4'h5, 8'h55, 8'h05, 0, 0, 0, 5'h00, 4'h0, 1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 0, "fl_s5");
        add(1, 5'h07, 4'h7, 8'h77, 8'h07, 0, 1, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "flush");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "post_flush");
        // Replay of a held beat
        add(1, 5'h02, 4'h2, 8'h22, 8'hAA, 0, 0, 0, 5'h00, 4'h0, 1, 5'h02, 3'h6, 4'h2, 4'h9, 8'h22, 8'hAA, 1, "rp_load");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 1, 5'h09, 4'h3, 1, 5'h09, 3'h2, 4'h3, 4'h1, 8'h22, 8'hAA, 1, "replay");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "rp_drain");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 1, 5'h0c, 4'h5, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "rp_ignored");
        // Replay while a new beat lands in the skid register
        add(1, 5'h08, 4'h8, 8'h88, 8'h08, 0, 0, 0, 5'h00, 4'h0, 1, 5'h08, 3'h6, 4'h8, 4'h9, 8'h88, 8'h08, 1, "rpi_o8");
        add(1, 5'h0a, 4'ha, 8'haa, 8'h0a, 1, 0, 1, 5'h0c, 4'h5, 1, 5'h0c, 3'h2, 4'h5, 4'h1, 8'h88, 8'h08, 0, "rpi_replay");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 1, 5'h0a, 3'h6, 4'ha, 4'h9, 8'haa, 8'h0a, 1, "rpi_drain");
        add(0, 5'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 5'h00, 4'h0, 0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1, "rpi_bubble");

        // Reset held low for two cycles, then idle
        @(posedge clk); #1;
        check_outputs("in_reset", 1'b0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs("idle", 1'b0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);

        foreach (vecs[i]) begin
            in_valid       = vecs[i].iv;
            in_opcode      = vecs[i].op;
            in_r1_addr     = vecs[i].r1a;
            in_r1_data     = vecs[i].r1d;
            in_rd_data     = vecs[i].rdd;
            out_ready      = vecs[i].ordy;
            flush          = vecs[i].fl;
            replay         = vecs[i].rp;
            replay_opcode  = vecs[i].rpop;
            replay_r1_addr = vecs[i].rpr1;
            @(posedge clk); #1;
            check_outputs(vecs[i].name, vecs[i].eov, vecs[i].eop, vecs[i].erda,
                          vecs[i].er1a, vecs[i].er2a, vecs[i].er1d, vecs[i].erdd, vecs[i].erdy);
        end

`ifdef IDEX_SKID_STATS_EN
        check("replay_cnt", {16'd0, replay_cnt}, 32'd2);
`endif

        // Asynchronous reset between clock edges with ov=sv=1
        drive_idle();
        in_valid = 1'b1; in_opcode = 5'h04; in_r1_addr = 4'h4; in_r1_data = 8'h44; in_rd_data = 8'h04;
        @(posedge clk); #1;
        in_opcode = 5'h05; in_r1_addr = 4'h5; in_r1_data = 8'h55; in_rd_data = 8'h05;
        @(posedge clk); #1;
        check_outputs("pre_arst", 1'b1, 5'h04, 3'h6, 4'h4, 4'h9, 8'h44, 8'h04, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_outputs("after_arst", 1'b0, 5'h1f, 3'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
